// File: rtl/datapath_sequencer_if.sv
// Execute bus between the sequencer and the datapath: one operation per valid/ready handshake.
interface datapath_sequencer_if;
    logic [2:0] alu_op;
    logic [7:0] imm;
    logic       exec_valid;
    logic       dp_ready;

    modport master (output alu_op, output imm, output exec_valid, input dp_ready);
    modport slave  (input alu_op, input imm, input exec_valid, output dp_ready);
endinterface

// File: rtl/datapath_sequencer.sv
// Steps a small ROM program into the datapath: fetch, load, then hold each operation until accepted.
module datapath_sequencer #(
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned LAST_ADDR = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [10:0]           rom_data,
    datapath_sequencer_if.master  dp,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned OP_W    = 3;
    localparam int unsigned IMM_W   = 8;
    localparam int unsigned INSTR_W = OP_W + IMM_W;
    localparam logic [OP_W-1:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        EXEC  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    pc_next;
    logic [INSTR_W-1:0]   ir;
    logic [INSTR_W-1:0]   ir_next;
    logic                 at_last;
    logic                 exec_next;
    logic [OP_W-1:0]      op_next;
    logic [IMM_W-1:0]     imm_next;
    logic                 busy_next;
    logic                 done_next;

    assign rom_addr = pc;
    assign at_last  = (pc == ADDR_W'(LAST_ADDR));

    // State, program counter, instruction register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= '0;
            ir            <= '0;
            dp.exec_valid <= 1'b0;
            dp.alu_op     <= '0;
            dp.imm        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            ir            <= ir_next;
            dp.exec_valid <= exec_next;
            dp.alu_op     <= op_next;
            dp.imm        <= imm_next;
            busy          <= busy_next;
            done          <= done_next;
        end
    end

    // Next state; outputs are decoded from the next state so they register in step with it
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;

        unique case (state)
            IDLE: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = FETCH;
                end
            end
            FETCH: state_next = LOAD;
            LOAD: begin
                ir_next    = rom_data;
                state_next = (rom_data[INSTR_W-1:IMM_W] == OP_HALT) ? DONE : EXEC;
            end
            EXEC: begin
                if (dp.dp_ready) begin
                    if (at_last) begin
                        state_next = DONE;
                    end else begin
                        pc_next    = pc + ADDR_W'(1);
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase

        exec_next = (state_next == EXEC);
        op_next   = exec_next ? ir_next[INSTR_W-1:IMM_W] : '0;
        imm_next  = exec_next ? ir_next[IMM_W-1:0] : '0;
        busy_next = (state_next == FETCH) || (state_next == LOAD) || (state_next == EXEC);
        done_next = (state_next == DONE);
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: cycle table for the opening of a run, handshake scoreboard for the rest.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  rom_addr;
    logic [10:0] rom_data;
    logic        busy;
    logic        done;
    logic [10:0] rom [8];

    int errors = 0;
    int checks = 0;

    datapath_sequencer_if bus ();

    datapath_sequencer #(.ADDR_W(3), .LAST_ADDR(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .dp       (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Program ROM with registered output
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        logic start;
        logic dp;
        int   addr;
        int   ev;
        int   op;
        int   imm;
        int   busy;
        int   done;
    } vec_t;

    typedef struct {
        int op;
        int imm;
    } hs_t;

    vec_t vecs [8];
    hs_t  prog_hs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input int addr, input int ev, input int op,
                               input int imm, input int bz, input int dn);
        chk({tag, ".rom_addr"},   int'(rom_addr),       addr);
        chk({tag, ".exec_valid"}, int'(bus.exec_valid), ev);
        chk({tag, ".alu_op"},     int'(bus.alu_op),     op);
        chk({tag, ".imm"},        int'(bus.imm),        imm);
        chk({tag, ".busy"},       int'(busy),           bz);
        chk({tag, ".done"},       int'(done),           dn);
    endtask

    // Drives dp_ready from the current observation and scores every handshake against prog_hs
    task automatic run_hs(input string tag, input int first_idx, input int n_hs,
                          input int stall_addr, input int stall_n, input int first_t,
                          input int done_gap, input int max_exp);
        int   idx        = first_idx;
        int   t          = 0;
        int   last_t     = -1;
        int   stall_left = stall_n;
        int   ev_run     = 0;
        int   max_addr   = 0;
        logic got_done   = 1'b0;
        while (!got_done && t < 200) begin
            if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (bus.exec_valid) begin
                    ev_run++;
                    if (int'(rom_addr) == stall_addr && stall_left > 0) begin
                        bus.dp_ready = 1'b0;
                        stall_left--;
                        chk({tag, ".stall_addr"}, int'(rom_addr), stall_addr);
                        chk({tag, ".stall_op"},   int'(bus.alu_op), prog_hs[stall_addr].op);
                        chk({tag, ".stall_imm"},  int'(bus.imm),    prog_hs[stall_addr].imm);
                    end else begin
                        bus.dp_ready = 1'b1;
                        if (idx >= n_hs) begin
                            chk({tag, ".hs_count_over"}, idx, n_hs - 1);
                        end else begin
                            chk({tag, ".hs_addr"}, int'(rom_addr),   idx);
                            chk({tag, ".hs_op"},   int'(bus.alu_op), prog_hs[idx].op);
                            chk({tag, ".hs_imm"},  int'(bus.imm),    prog_hs[idx].imm);
                            if (last_t >= 0)
                                chk({tag, ".hs_gap"}, t - last_t,
                                    3 + ((stall_n > 0 && idx == stall_addr) ? stall_n : 0));
                            else if (first_t >= 0)
                                chk({tag, ".first_exec"}, t, first_t);
                            if (stall_n > 0 && idx == stall_addr)
                                chk({tag, ".stall_valid_len"}, ev_run, stall_n + 1);
                        end
                        ev_run = 0;
                        last_t = t;
                        idx++;
                    end
                end else begin
                    ev_run = 0;
                    bus.dp_ready = 1'($urandom_range(0, 1));
                end
                step();
                t++;
            end
        end
        bus.dp_ready = 1'b1;
        chk({tag, ".done_reached"}, int'(got_done), 1);
        chk({tag, ".hs_total"}, idx, n_hs);
        chk({tag, ".max_addr"}, max_addr, max_exp);
        if (got_done && last_t >= 0)
            chk({tag, ".done_gap"}, t - last_t, done_gap);
    endtask

    initial begin
        rom[0] = 11'h400; rom[1] = 11'h070; rom[2] = 11'h10C; rom[3] = 11'h502;
        rom[4] = 11'h400; rom[5] = 11'h080; rom[6] = 11'h080; rom[7] = 11'h400;

        prog_hs[0] = '{4, 'h00}; prog_hs[1] = '{0, 'h70};
        prog_hs[2] = '{1, 'h0C}; prog_hs[3] = '{5, 'h02};
        prog_hs[4] = '{4, 'h00}; prog_hs[5] = '{0, 'h80};
        prog_hs[6] = '{0, 'h80}; prog_hs[7] = '{4, 'h00};

        // start, dp_ready, rom_addr, exec_valid, alu_op, imm, busy, done (seen after the edge)
        vecs[0] = '{1'b1, 1'b0, 0, 0, 0, 'h00, 1, 0};
        vecs[1] = '{1'b0, 1'b0, 0, 0, 0, 'h00, 1, 0};
        vecs[2] = '{1'b0, 1'b1, 0, 1, 4, 'h00, 1, 0};
        vecs[3] = '{1'b0, 1'b1, 1, 0, 0, 'h00, 1, 0};
        vecs[4] = '{1'b1, 1'b0, 1, 0, 0, 'h00, 1, 0};
        vecs[5] = '{1'b0, 1'b0, 1, 1, 0, 'h70, 1, 0};
        vecs[6] = '{1'b1, 1'b0, 1, 1, 0, 'h70, 1, 0};
        vecs[7] = '{1'b0, 1'b1, 2, 0, 0, 'h00, 1, 0};

        rst = 1'b1;
        start = 1'b1;
        bus.dp_ready = 1'b1;
        step();
        step();
        chk_outputs("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        start = 1'b0;
        step();
        chk_outputs("idle", 0, 0, 0, 0, 0, 0);

        // Opening of a run, including a busy-time start pulse and a one-cycle stall
        for (int i = 0; i < 8; i++) begin
            start = vecs[i].start;
            bus.dp_ready = vecs[i].dp;
            step();
            chk_outputs($sformatf("vec%0d", i), vecs[i].addr, vecs[i].ev, vecs[i].op,
                        vecs[i].imm, vecs[i].busy, vecs[i].done);
        end
        start = 1'b0;

        // Remaining program with a four-cycle stall at address 2
        run_hs("run1", 2, 8, 2, 4, -1, 1, 7);

        // Restart from DONE
        start = 1'b1;
        step();
        start = 1'b0;
        chk_outputs("restart", 0, 0, 0, 0, 1, 0);
        run_hs("run2", 0, 8, -1, 0, 2, 1, 7);

        // HALT at address 3 ends the run early
        rom[3] = 11'h700;
        start = 1'b1;
        step();
        start = 1'b0;
        run_hs("halt", 0, 3, -1, 0, 2, 3, 3);
        rom[3] = 11'h502;

        // Reset while address 5 is waiting in EXEC
        begin
            int   n     = 0;
            logic found = 1'b0;
            start = 1'b1;
            step();
            start = 1'b0;
            bus.dp_ready = 1'b1;
            while (!found && n < 100) begin
                if (bus.exec_valid && rom_addr == 3'd5) found = 1'b1;
                else begin
                    step();
                    n++;
                end
            end
            chk("rst_mid.reach_addr5", int'(found), 1);
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk_outputs("rst_mid", 0, 0, 0, 0, 0, 0);
            start = 1'b1;
            step();
            start = 1'b0;
            chk_outputs("rst_restart", 0, 0, 0, 0, 1, 0);
            step();
            step();
            chk_outputs("rst_first_exec", 0, 1, 4, 'h00, 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
